ram_com_rd: RTL and testbench



---
 rtl/cube0414_pkg.sv | 29 ++
 rtl/ram_layer_mux.sv | 20 ++
 rtl/ram_com_rd.sv | 150 +++++++++++++++
 tb/tb_ram_com_rd.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cube0414_pkg.sv
// Shared definitions for the LED cube RAM read/write path.
package cube0414_pkg;

  localparam int unsigned LAYERS  = 8;
  localparam int unsigned PIXELS  = 64;
  localparam int unsigned DATA_W  = 24;
  localparam int unsigned ADDR_W  = $clog2(PIXELS);
  localparam int unsigned LAYER_W = $clog2(LAYERS);
  localparam int unsigned IDX_W   = LAYER_W + ADDR_W;

  // Host command bytes understood by the SPI-side RAM writer.
  localparam logic [7:0] CUBE0414_ADDR_WR = 8'hcc;
  localparam logic [7:0] CUBE0414_DATA_WR = 8'hda;

  // Read-engine states.
  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StHold,
    StDone
  } rd_state_e;

  // Advance a one-hot layer select to the next layer.
  function automatic logic [LAYERS-1:0] layer_rotl(input logic [LAYERS-1:0] sel);
    return {sel[LAYERS-2:0], sel[LAYERS-1]};
  endfunction

endpackage

// File: rtl/ram_layer_mux.sv
// One-hot layer select to a single DATA_W word from the concatenated layer read data.
module ram_layer_mux
  import cube0414_pkg::*;
(
  input  logic [LAYERS-1:0]        layer_sel_i,
  input  logic [LAYERS*DATA_W-1:0] ram_rd_data_i,
  output logic [DATA_W-1:0]        data_o
);

  // AND-OR select; an all-zero select yields zero.
  always_comb begin
    data_o = '0;
    for (int k = 0; k < int'(LAYERS); k++) begin
      if (layer_sel_i[k]) begin
        data_o = data_o | ram_rd_data_i[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/ram_com_rd.sv
// Frame-read engine: scans all layers and addresses, reads the layer RAMs and streams each
// pixel to the serializer over valid/ready, then pulses frame_done_out.
module ram_com_rd
  import cube0414_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1  // 1..3
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     read_en_in,
  output logic                     ram_rd_en_out,
  output logic [ADDR_W-1:0]        ram_rd_addr_out,
  output logic [LAYERS-1:0]        layer_sel_out,
  input  logic [LAYERS*DATA_W-1:0] ram_rd_data_in,
  output logic [DATA_W-1:0]        pixel_data_out,
  output logic                     pixel_valid_out,
  input  logic                     pixel_ready_in,
  output logic [IDX_W-1:0]         pixel_idx_out,
  output logic                     frame_done_out,
  output logic                     busy_out
);

  localparam logic [LAYERS-1:0]  FirstLayerSel = LAYERS'(1);
  localparam logic [ADDR_W-1:0]  LastAddr      = ADDR_W'(PIXELS - 1);
  localparam logic [LAYER_W-1:0] LastLayer     = LAYER_W'(LAYERS - 1);
  localparam logic [1:0]         WaitLast      = 2'(RD_LATENCY - 1);

  rd_state_e           state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LAYER_W-1:0]  layer_q, layer_d;
  logic [LAYERS-1:0]   layer_sel_q, layer_sel_d;
  logic [DATA_W-1:0]   pixel_q, pixel_d;
  logic [1:0]          wait_cnt_q, wait_cnt_d;
  logic                restart_q, restart_d;
  logic [DATA_W-1:0]   mux_data;
  logic                last_pixel;

  ram_layer_mux u_layer_mux (
    .layer_sel_i   (layer_sel_q),
    .ram_rd_data_i (ram_rd_data_in),
    .data_o        (mux_data)
  );

  assign last_pixel = (layer_q == LastLayer) && (addr_q == LastAddr);

  // Next-state logic: frame scan, read-latency wait, handshake and restart bookkeeping.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    layer_d     = layer_q;
    layer_sel_d = layer_sel_q;
    pixel_d     = pixel_q;
    wait_cnt_d  = wait_cnt_q;
    restart_d   = restart_q;

    // A start request during an active frame is remembered, never acted on mid-frame.
    if (read_en_in && (state_q inside {StFetch, StWait, StHold})) begin
      restart_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (read_en_in) begin
          state_d     = StFetch;
          addr_d      = '0;
          layer_d     = '0;
          layer_sel_d = FirstLayerSel;
        end
      end
      StFetch: begin
        state_d    = StWait;
        wait_cnt_d = '0;
      end
      StWait: begin
        if (wait_cnt_q == WaitLast) begin
          pixel_d = mux_data;
          state_d = StHold;
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end
      StHold: begin
        if (pixel_ready_in) begin
          if (last_pixel) begin
            state_d = StDone;
          end else begin
            state_d = StFetch;
            if (addr_q == LastAddr) begin
              addr_d      = '0;
              layer_d     = layer_q + LAYER_W'(1);
              layer_sel_d = layer_rotl(layer_sel_q);
            end else begin
              addr_d = addr_q + ADDR_W'(1);
            end
          end
        end
      end
      StDone: begin
        addr_d  = '0;
        layer_d = '0;
        // A start arriving in this very cycle counts as a pending restart.
        if (restart_q || read_en_in) begin
          state_d     = StFetch;
          restart_d   = 1'b0;
          layer_sel_d = FirstLayerSel;
        end else begin
          state_d     = StIdle;
          layer_sel_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      layer_q     <= '0;
      layer_sel_q <= '0;
      pixel_q     <= '0;
      wait_cnt_q  <= '0;
      restart_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      layer_q     <= layer_d;
      layer_sel_q <= layer_sel_d;
      pixel_q     <= pixel_d;
      wait_cnt_q  <= wait_cnt_d;
      restart_q   <= restart_d;
    end
  end

  // Outputs decoded from the state register; counters drive address and index directly.
  always_comb begin
    ram_rd_en_out   = (state_q == StFetch);
    pixel_valid_out = (state_q == StHold);
    frame_done_out  = (state_q == StDone);
    busy_out        = (state_q != StIdle);
    ram_rd_addr_out = addr_q;
    layer_sel_out   = layer_sel_q;
    pixel_data_out  = pixel_q;
    pixel_idx_out   = {layer_q, addr_q};
  end

endmodule

// File: tb/tb_ram_com_rd.sv
// Randomized bench for ram_com_rd: frame scan, backpressure, restart, mid-frame reset and a
// RD_LATENCY=3 instance, checked against a pixel-sequence model of the frame.
module tb_ram_com_rd;
  import cube0414_pkg::*;

  localparam int L1 = 1;
  localparam int L3 = 3;
  localparam int NPIX = LAYERS * PIXELS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared stimulus
  logic rst, rd_en_req, ready, start3;
  logic ready3 = 1'b1;

  // DUT with latency 1
  logic                     ram_en1, valid1, done1, busy1;
  logic [5:0]               addr1;
  logic [7:0]               sel1;
  logic [LAYERS*DATA_W-1:0] rdata1;
  logic [23:0]              pdata1;
  logic [8:0]               idx1;

  // DUT with latency 3
  logic                     ram_en3, valid3, done3, busy3;
  logic [5:0]               addr3;
  logic [7:0]               sel3;
  logic [LAYERS*DATA_W-1:0] rdata3;
  logic [LAYERS*DATA_W-1:0] pipe3 [3];
  logic [23:0]              pdata3;
  logic [8:0]               idx3;

  logic [23:0] mem [LAYERS][PIXELS];

  ram_com_rd #(.RD_LATENCY(L1)) dut (
    .clk_in(clk), .rst_in(rst), .read_en_in(rd_en_req), .ram_rd_en_out(ram_en1),
    .ram_rd_addr_out(addr1), .layer_sel_out(sel1), .ram_rd_data_in(rdata1),
    .pixel_data_out(pdata1), .pixel_valid_out(valid1), .pixel_ready_in(ready),
    .pixel_idx_out(idx1), .frame_done_out(done1), .busy_out(busy1)
  );

  ram_com_rd #(.RD_LATENCY(L3)) dut3 (
    .clk_in(clk), .rst_in(rst), .read_en_in(start3), .ram_rd_en_out(ram_en3),
    .ram_rd_addr_out(addr3), .layer_sel_out(sel3), .ram_rd_data_in(rdata3),
    .pixel_data_out(pdata3), .pixel_valid_out(valid3), .pixel_ready_in(ready3),
    .pixel_idx_out(idx3), .frame_done_out(done3), .busy_out(busy3)
  );

  function automatic logic [LAYERS*DATA_W-1:0] row(input logic [5:0] a);
    logic [LAYERS*DATA_W-1:0] r;
    for (int k = 0; k < LAYERS; k++) r[k*DATA_W +: DATA_W] = mem[k][a];
    return r;
  endfunction

  function automatic logic [LAYERS*DATA_W-1:0] rand_row();
    logic [LAYERS*DATA_W-1:0] r;
    for (int k = 0; k < LAYERS; k++) r[k*DATA_W +: DATA_W] = 24'($urandom);
    return r;
  endfunction

  function automatic logic [23:0] exp_word(input int p);
    return mem[p / PIXELS][p % PIXELS];
  endfunction

  // RAM models: read data is only meaningful exactly RD_LATENCY cycles after a strobe.
  always @(posedge clk) rdata1 <= ram_en1 ? row(addr1) : rand_row();
  always @(posedge clk) begin
    pipe3[0] <= ram_en3 ? row(addr3) : rand_row();
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign rdata3 = pipe3[2];

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model state for the latency-1 DUT
  bit mon_en = 1'b0;
  bit busy_m = 1'b0, pending = 1'b0, prev_valid = 1'b0, prev_hs = 1'b0;
  int exp_idx = 0, valid_due = -1, done_due = -1, fetch_due = -1;
  int rd_cnt = 0, idle_rd = 0, frames_done = 0, restart_fetches = 0;

  // Ready driver
  int rdy_mode = 0, stall_idx = -1, stall_left = 0;
  initial begin
    ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0 && valid1 && exp_idx == stall_idx) begin
        ready = 1'b0;
        stall_left--;
      end else begin
        ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor: compare the DUT each cycle with the frame model, then advance the model.
  always @(negedge clk) begin
    logic hs;
    if (mon_en) begin
      check_eq("busy", 32'(busy1), 32'(busy_m));
      check_eq("frame_done", 32'(done1), 32'(cyc == done_due));
      if (cyc == fetch_due) begin
        check_eq("restart_fetch", 32'(ram_en1), 32'd1);
        restart_fetches++;
      end
      if (ram_en1) begin
        rd_cnt++;
        if (!busy_m) idle_rd++;
      end
      if (valid1) begin
        check_eq("rd_en_in_hold", 32'(ram_en1), 32'd0);
        check_eq("pix_idx", 32'(idx1), exp_idx);
        check_eq("pix_data", 32'(pdata1), 32'(exp_word(exp_idx % NPIX)));
        check_eq("layer_sel", 32'(sel1), 32'd1 << (exp_idx / PIXELS));
        if (!prev_valid) check_eq("valid_rise_cycle", cyc, valid_due);
      end
      if (prev_hs) check_eq("valid_after_hs", 32'(valid1), 32'd0);
      hs = valid1 && ready;

      if (rst) begin
        busy_m = 1'b0; pending = 1'b0; exp_idx = 0; rd_cnt = 0;
        valid_due = -1; done_due = -1; fetch_due = -1;
        prev_valid = 1'b0; prev_hs = 1'b0;
      end else begin
        if (hs) begin
          if (exp_idx == NPIX - 1) done_due = cyc + 1;
          else valid_due = cyc + 2 + L1;
          exp_idx++;
        end
        if (rd_en_req) begin
          if (!busy_m) begin
            busy_m = 1'b1; exp_idx = 0; rd_cnt = 0; valid_due = cyc + 2 + L1;
          end else begin
            pending = 1'b1;
          end
        end
        if (cyc == done_due) begin
          check_eq("rd_cnt_frame", rd_cnt, NPIX);
          frames_done++;
          if (pending) begin
            pending = 1'b0; exp_idx = 0; rd_cnt = 0;
            valid_due = cyc + 2 + L1; fetch_due = cyc + 1;
          end else begin
            busy_m = 1'b0;
          end
        end
        prev_valid = valid1;
        prev_hs = hs;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 rd_en_req = 1'b1;
    @(posedge clk); #1 rd_en_req = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, input string tag);
    int k = 0;
    while (frames_done < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    check_eq(tag, frames_done, n);
  endtask

  task automatic wait_idx(input int n, input int budget, input string tag);
    int k = 0;
    while (exp_idx < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    check_eq(tag, 32'(exp_idx >= n), 32'd1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_rd_en"}, 32'(ram_en1), 32'd0);
    check_eq({tag, "_addr"},  32'(addr1),   32'd0);
    check_eq({tag, "_sel"},   32'(sel1),    32'd0);
    check_eq({tag, "_data"},  32'(pdata1),  32'd0);
    check_eq({tag, "_valid"}, 32'(valid1),  32'd0);
    check_eq({tag, "_idx"},   32'(idx1),    32'd0);
    check_eq({tag, "_done"},  32'(done1),   32'd0);
    check_eq({tag, "_busy"},  32'(busy1),   32'd0);
  endtask

  task automatic apply_reset(input string tag);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero(tag);
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    int s3, k3, hs3;
    bit pv3, got_done3;
    for (int l = 0; l < LAYERS; l++)
      for (int a = 0; a < PIXELS; a++) mem[l][a] = {8'(l), 8'($urandom), 8'(a)};
    rst = 1'b1; rd_en_req = 1'b0; start3 = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;
    @(negedge clk);
    check_outputs_zero("reset");
    check_eq("reset_busy3", 32'(busy3), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    // Full frame, ready high, 10-cycle stall on pixel 63
    stall_idx = 63; stall_left = 10;
    pulse_start();
    wait_frames(1, 3000, "frame1_done");
    check_eq("stall_consumed", stall_left, 0);

    // Random backpressure, two start pulses mid-frame collapse into one restart
    rdy_mode = 1;
    pulse_start();
    wait_idx(200, 3000, "reach_px200");
    pulse_start();
    repeat (5) @(posedge clk);
    pulse_start();
    wait_frames(3, 8000, "restart_frames_done");
    repeat (20) @(posedge clk);
    check_eq("single_restart", frames_done, 3);
    check_eq("restart_fetch_count", restart_fetches, 1);

    // Reset mid-frame, then a fresh frame from index 0
    pulse_start();
    wait_idx(300, 3000, "reach_px300");
    apply_reset("midreset");
    repeat (10) @(posedge clk);
    check_eq("no_busy_after_reset", 32'(busy1), 32'd0);
    pulse_start();
    wait_frames(4, 4000, "post_reset_frame");
    check_eq("no_idle_rd", idle_rd, 0);

    // RD_LATENCY = 3 instance
    @(posedge clk); #1 start3 = 1'b1; s3 = cyc;
    @(posedge clk); #1 start3 = 1'b0;
    k3 = 0; hs3 = -1; pv3 = 1'b0; got_done3 = 1'b0;
    for (int n = 0; n < 4000 && !got_done3; n++) begin
      @(negedge clk);
      if (valid3 && !pv3) check_eq("l3_valid_rise", cyc - ((k3 == 0) ? s3 : hs3), 2 + L3);
      if (valid3) begin
        check_eq("l3_idx", 32'(idx3), k3);
        check_eq("l3_data", 32'(pdata3), 32'(exp_word(k3 % NPIX)));
        hs3 = cyc;
        k3++;
      end
      if (done3) begin
        check_eq("l3_done_cycle", cyc - hs3, 1);
        got_done3 = 1'b1;
      end
      pv3 = valid3;
    end
    check_eq("l3_pixel_count", k3, NPIX);
    check_eq("l3_frame_done", 32'(got_done3), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
